latch_bank: RTL
===============

# latch_bank

Parametrised multi-channel strobe-capture register bank; clocked, double-buffered successor to the single gated D latch. Each channel holds a shadow word written by a strobe and an active word updated only on a commit, so a group of channels can be staged and then switched atomically. The bank sits between a configuration or stimulus source and downstream logic that must see coherent multi-channel values. It reports dirty-channel tracking, a commit-done pulse and a sticky address error.

## Interface
- WIDTH, 8, data bits per channel
- CH, 4, number of channels (>= 1)
- AW, 2, address width; CH <= 2**AW required
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- st  in  1  write strobe
- a  in  AW  write channel address
- d  in  WIDTH  write data
- bc  in  1  broadcast; with st, write all channels, a ignored
- cm  in  1  commit request
- ra  in  AW  read channel address
- o  out  WIDTH  active word of channel ra
- so  out  WIDTH  shadow word of channel ra
- dirty  out  CH  per-channel shadow-differs-from-commit flag
- ndirty  out  AW+1  population count of dirty
- cd  out  1  commit-done pulse
- err  out  1  sticky illegal-address flag

## Operation
- State: shadow[CH], active[CH], dirty[CH], cd, err; all reset to 0.
- Write, st=1 and bc=0 and a<CH: shadow[a] <= d, dirty[a] <= 1.
- Broadcast, st=1 and bc=1: every shadow[i] <= d, all dirty <= 1; err unaffected.
- Illegal write, st=1 and bc=0 and a>=CH: no shadow change; err <= 1, held until rst.
- Commit, cm=1: for every i with dirty[i]=1, active[i] <= shadow[i]; clean channels are unchanged. All dirty bits are cleared, and cd <= 1 for exactly one cycle.
- Commit with no dirty channels: active is unchanged, but cd still pulses.
- Simultaneous st and cm, same edge:
  - Commit copies the pre-edge shadow values.
  - The write then lands in shadow.
  - Written channels end with dirty=1; all other dirty bits are cleared.
- Back-to-back cm on consecutive cycles: cd stays high for both cycles.
- Reads are combinational from registers:
  - o = active[ra] and so = shadow[ra].
  - If ra>=CH, both read 0.
- ndirty is the combinational popcount of the dirty register. Range is 0..CH.
- rst=1 takes priority over st and cm in the same cycle. All state clears, including err and cd.

## Timing
- Write latency: so and dirty reflect the write on the cycle after the strobe edge.
- Commit latency: o reflects the new value, and dirty and ndirty read 0, on the cycle after the cm edge. cd is high during that same cycle.
- No handshake or backpressure; st and cm are accepted every cycle.
- Reset mid-operation: a pending commit is discarded. Outputs read 0 on the cycle after the rst edge.
- Changing ra affects o and so in the same cycle, with no register stage.

## Configuration
- LATCH_BANK_BYPASS_EN defined: so is transparent, like a gated latch.
  - Condition: st=1, ra<CH, and (bc=1 or a==ra).
  - When the condition holds, so = d combinationally in the same cycle; otherwise so = shadow[ra].
  - o, dirty and all state updates are unaffected.
- LATCH_BANK_BYPASS_EN undefined: so = shadow[ra] always, so a write becomes visible only after the edge.

## Test plan
- Reset, single write: assert rst, then write d=0x5A to a=2 → so(ra=2)=0x5A next cycle, o=0, dirty=4'b0100, ndirty=1.
- Commit: after the above, pulse cm → next cycle o(ra=2)=0x5A, dirty=0, cd=1 for one cycle; channels 0, 1 and 3 stay 0.
- Broadcast plus collision:
  - Broadcast d=0xFF, then assert st (a=1, d=0x11) together with cm.
  - Required: active is all 0xFF, shadow[1]=0x11, dirty=4'b0010.
- Illegal address: CH=3, AW=2, write a=3 → no shadow change, err=1 and held across later legal writes, cleared only by rst.
- Reset mid-commit: assert rst and cm in the same cycle after dirty writes → active stays 0, cd=0, dirty=0.
- Bypass:
  - With LATCH_BANK_BYPASS_EN defined: st=1, a=ra=0, d=0x3C → so=0x3C in the same cycle.
  - With LATCH_BANK_BYPASS_EN undefined: so shows 0x3C only after the edge.

Source files
------------

// File: rtl/latch_bank.sv
// Double-buffered multi-channel strobe-capture bank: strobed shadow words, atomic commit to active words.
// Optional LATCH_BANK_BYPASS_EN makes the shadow read transparent to an in-flight strobe, like a gated latch.
module latch_bank #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st,
  input  logic [AW-1:0]    a,
  input  logic [WIDTH-1:0] d,
  input  logic             bc,
  input  logic             cm,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] so,
  output logic [CH-1:0]    dirty,
  output logic [AW:0]      ndirty,
  output logic             cd,
  output logic             err
);

  localparam logic [AW:0] CH_L = (AW+1)'(CH);

  logic [WIDTH-1:0] shadow [CH];
  logic [WIDTH-1:0] active [CH];
  logic [CH-1:0]    wr_mask;
  logic             a_ok;
  logic [WIDTH-1:0] rd_active;
  logic [WIDTH-1:0] rd_shadow;

  assign a_ok = ({1'b0, a} < CH_L);

  always_comb begin
    wr_mask = '0;
    if (st) begin
      if (bc) begin
        wr_mask = '1;
      end else begin
        for (int i = 0; i < CH; i++) begin
          if (a == AW'(i)) wr_mask[i] = 1'b1;
        end
      end
    end
  end

  // Commit reads the pre-edge shadow, so a same-edge write lands after the copy and stays dirty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      dirty <= '0;
      cd    <= 1'b0;
      err   <= 1'b0;
    end else begin
      cd <= cm;
      for (int i = 0; i < CH; i++) begin
        if (cm && dirty[i]) active[i] <= shadow[i];
        if (wr_mask[i]) shadow[i] <= d;
      end
      dirty <= (cm ? '0 : dirty) | wr_mask;
      if (st && !bc && !a_ok) err <= 1'b1;
    end
  end

  always_comb begin
    rd_active = '0;
    rd_shadow = '0;
    for (int i = 0; i < CH; i++) begin
      if (ra == AW'(i)) begin
        rd_active = active[i];
        rd_shadow = shadow[i];
      end
    end
  end

  assign o = rd_active;

`ifdef LATCH_BANK_BYPASS_EN
  logic ra_ok;
  logic bypass_hit;
  assign ra_ok      = ({1'b0, ra} < CH_L);
  assign bypass_hit = st && ra_ok && (bc || (a == ra));
  assign so         = bypass_hit ? d : rd_shadow;
`else
  assign so = rd_shadow;
`endif

  always_comb begin
    ndirty = '0;
    for (int i = 0; i < CH; i++) begin
      ndirty = ndirty + (AW+1)'(dirty[i]);
    end
  end

endmodule
